exe_stage_mc: RTL

EXE_STAGE_MC -- requirements
Module: exe_stage_mc

---
 rtl/exe_stage_mc.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with ALU, branch resolve and an optional
// shift-add multiplier, valid/ready handshaked on both sides.
//
// Optional feature macro: EXE_MUL_EN (enables the multi-cycle multiplier
// for exe_cmd 10; when undefined cmd 10 returns 0 and busy is tied low).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              squash in-flight op and held result
//   in_valid/in_ready  operand bundle handshake
//   exe_cmd            ALU op select (0..15)
//   branch_type        0 none, 1 BEZ, 2 BNE, 3 JUMP
//   val1, val2         ALU operands (val2 also branch offset)
//   src2_val, pc       BNE compare value, program counter
//   out_valid/out_ready result handshake
//   alu_result         registered ALU result
//   branch_address     registered pc + val2
//   branch_taken       registered branch decision
//   busy               multiply in progress
module exe_stage_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic [1:0]       branch_type,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] src2_val,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] branch_address,
    output logic             branch_taken,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu;
    logic [WIDTH-1:0] r_baddr;
    logic             r_btaken;

    logic [SW-1:0]    w_shamt;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_baddr;
    logic             w_btaken;
    logic             w_accept;

`ifdef EXE_MUL_EN
    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_pbaddr;
    logic             r_pbtaken;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_acc_nxt;

    assign busy      = r_busy;
    assign w_is_mul  = (exe_cmd == 4'd10);
    assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
`else
    assign busy = 1'b0;
`endif

    assign in_ready = !rst && !busy && !flush
                    && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign out_valid      = r_out_valid;
    assign alu_result     = r_alu;
    assign branch_address = r_baddr;
    assign branch_taken   = r_btaken;

    assign w_shamt = val2[SW-1:0];
    assign w_slt   = $signed(val1) < $signed(val2);
    assign w_baddr = pc + val2;

    // cmd 10 falls to the default here; with the multiplier enabled it
    // never reaches this path's result register.
    always_comb begin
        w_alu = '0;
        case (exe_cmd)
            4'd0:    w_alu = val1 + val2;
            4'd1:    w_alu = val1 - val2;
            4'd2:    w_alu = val1 & val2;
            4'd3:    w_alu = val1 | val2;
            4'd4:    w_alu = ~(val1 | val2);
            4'd5:    w_alu = val1 ^ val2;
            4'd6:    w_alu = val1 << w_shamt;
            4'd7:    w_alu = val1 >> w_shamt;
            4'd8:    w_alu = $signed(val1) >>> w_shamt;
            4'd9:    w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_btaken = 1'b0;
        unique case (branch_type)
            2'd0: w_btaken = 1'b0;
            2'd1: w_btaken = (val1 == '0);
            2'd2: w_btaken = (val1 != src2_val);
            2'd3: w_btaken = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_alu       <= '0;
            r_baddr     <= '0;
            r_btaken    <= 1'b0;
`ifdef EXE_MUL_EN
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_pbaddr    <= '0;
            r_pbtaken   <= 1'b0;
`endif
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
`ifdef EXE_MUL_EN
            r_busy      <= 1'b0;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
`ifdef EXE_MUL_EN
                        // Branch results wait in r_pb* so the visible
                        // outputs only move when the product lands.
                        if (w_is_mul) begin
                            r_state     <= S_MUL;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b1;
                            r_cnt       <= '0;
                            r_acc       <= '0;
                            r_mcand     <= val1;
                            r_mplier    <= val2;
                            r_pbaddr    <= w_baddr;
                            r_pbtaken   <= w_btaken;
                        end else
`endif
                        begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_alu       <= w_alu;
                            r_baddr     <= w_baddr;
                            r_btaken    <= w_btaken;
                        end
                    end else if (r_state == S_HOLD && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
`ifdef EXE_MUL_EN
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Last bit consumed: counter reaches WIDTH here.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_alu       <= w_acc_nxt;
                        r_baddr     <= r_pbaddr;
                        r_btaken    <= r_pbtaken;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
